// File: rtl/phase_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phase_pkg
//  Description : Shared types and constants for the instruction phase
//                sequencer. It holds the phase (state) encoding, the
//                instruction classes, the opcode field constants and the
//                instruction classifier.
//  Revision    : 1.0  initial release
// ============================================================================
package phase_pkg;

    // The encoding is visible on the PHASE output, so it must stay fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4
    } phase_e;

    typedef enum logic [2:0] {
        CLS_NOP = 3'd0,
        CLS_DP  = 3'd1,
        CLS_LDR = 3'd2,
        CLS_STR = 3'd3,
        CLS_B   = 3'd4,
        CLS_BL  = 3'd5
    } instr_class_e;

    // Opcode field values, taken from IR[27:25].
    localparam logic [1:0] C_OP_DP     = 2'b00;   // IR[27:26]
    localparam logic [1:0] C_OP_XFER   = 2'b01;   // IR[27:26]
    localparam logic [2:0] C_OP_BRANCH = 3'b101;  // IR[27:25]

    // The classifier takes only the bits it decodes:
    //   op_hi    = IR[27:25]
    //   link_bit = IR[24]
    //   load_bit = IR[20]
    function automatic instr_class_e classify(
        input logic [2:0] op_hi,
        input logic       link_bit,
        input logic       load_bit
    );
        instr_class_e cls;
        if (op_hi[2:1] == C_OP_DP) begin
            cls = CLS_DP;
        end else if (op_hi[2:1] == C_OP_XFER) begin
            cls = load_bit ? CLS_LDR : CLS_STR;
        end else if (op_hi == C_OP_BRANCH) begin
            cls = link_bit ? CLS_BL : CLS_B;
        end else begin
            cls = CLS_NOP;
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_change_detector.sv
`default_nettype none
// ============================================================================
//  Module      : instr_change_detector
//  Description : Remembers the last accepted instruction word. NEW_WORD is
//                high when no word is remembered, or when WORD differs from
//                the remembered word.
//  Ports       : HF_CLK   - clock (rising edge)
//                RST      - synchronous active-high reset
//                WORD     - current instruction word
//                CAPTURE  - the word is being accepted this cycle
//                FLUSH    - forget the remembered word
//                NEW_WORD - WORD is eligible for acceptance
//  Revision    : 1.0  initial release
// ============================================================================
module instr_change_detector (
    input  logic        HF_CLK,
    input  logic        RST,
    input  logic [31:0] WORD,
    input  logic        CAPTURE,
    input  logic        FLUSH,
    output logic        NEW_WORD
);

    logic [31:0] r_last_word;
    logic        r_last_valid;

    always_ff @(posedge HF_CLK) begin
        if (RST) begin
            r_last_word  <= 32'd0;
            r_last_valid <= 1'b0;
        end else begin
            if (CAPTURE) begin
                r_last_word <= WORD;
            end
            // FLUSH wins over a capture in the same cycle. This lets the
            // word just taken re-execute if it is presented again.
            if (FLUSH) begin
                r_last_valid <= 1'b0;
            end else if (CAPTURE) begin
                r_last_valid <= 1'b1;
            end
        end
    end

    assign NEW_WORD = !r_last_valid || (WORD != r_last_word);

endmodule
`default_nettype wire

// File: rtl/instruction_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_phase_sequencer
//  Description : Multi-cycle control sequencer for a simple core. It steps
//                through IDLE -> DECODE -> EXECUTE -> (MEMORY) -> WRITEBACK
//                and produces the datapath strobes for each phase. It also
//                counts retired instructions.
//  Ports       : HF_CLK, RST            - clock / synchronous active-high reset
//                INSTRUCTION, INSTR_VALID - instruction fetch interface
//                FLUSH                   - re-arm acceptance of identical word
//                STALL                   - freeze sequencing
//                MEM_READY               - data-memory acknowledge
//                IR_EN, PC_EN, REG_WE, MEM_REQ, MEM_WE, RETIRE - strobes
//                BUSY, PHASE, RETIRED_COUNT                   - status
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_phase_sequencer
    import phase_pkg::*;
(
    input  logic        HF_CLK,
    input  logic        RST,
    input  logic [31:0] INSTRUCTION,
    input  logic        INSTR_VALID,
    input  logic        FLUSH,
    input  logic        STALL,
    input  logic        MEM_READY,
    output logic        IR_EN,
    output logic        PC_EN,
    output logic        REG_WE,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic        RETIRE,
    output logic        BUSY,
    output logic [2:0]  PHASE,
    output logic [15:0] RETIRED_COUNT
);

    phase_e       r_state;
    phase_e       w_state_nxt;
    logic [31:0]  r_ir;
    logic [15:0]  r_retired_count;
    logic         r_rst_q;
    logic         w_new_word;
    logic         w_accept;
    logic         w_is_xfer;
    instr_class_e w_class;

    // Only the classification fields of IR are consumed here. The rest of
    // the register belongs to the datapath.
    logic         w_unused_ir;
    assign w_unused_ir = ^{r_ir[31:28], r_ir[23:21], r_ir[19:0]};

    assign w_class   = classify(r_ir[27:25], r_ir[24], r_ir[20]);
    assign w_is_xfer = (w_class == CLS_LDR) || (w_class == CLS_STR);

    // Acceptance is blocked while reset is high and for one cycle after it.
    // The first cycle out of reset therefore shows no strobes, even if a
    // valid word is already waiting.
    assign w_accept = !RST && !r_rst_q && (r_state == ST_IDLE) &&
                      INSTR_VALID && !STALL && w_new_word;

    instr_change_detector u_change_det (
        .HF_CLK   (HF_CLK),
        .RST      (RST),
        .WORD     (INSTRUCTION),
        .CAPTURE  (w_accept),
        .FLUSH    (FLUSH),
        .NEW_WORD (w_new_word)
    );

    // ---------------- state register ----------------
    always_ff @(posedge HF_CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- IR, counter, reset history ----------------
    always_ff @(posedge HF_CLK) begin
        r_rst_q <= RST;
        if (RST) begin
            r_ir            <= 32'd0;
            r_retired_count <= 16'd0;
        end else begin
            if (w_accept) begin
                r_ir <= INSTRUCTION;
            end
            if (RETIRE) begin
                r_retired_count <= r_retired_count + 16'd1;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!STALL) begin
                    w_state_nxt = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (!STALL) begin
                    w_state_nxt = w_is_xfer ? ST_MEMORY : ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                // While stalled, an acknowledge is ignored, not remembered.
                if (!STALL && MEM_READY) begin
                    w_state_nxt = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                if (!STALL) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        IR_EN   = w_accept;
        PC_EN   = 1'b0;
        REG_WE  = 1'b0;
        MEM_REQ = 1'b0;
        MEM_WE  = 1'b0;
        RETIRE  = 1'b0;
        BUSY    = 1'b0;
        if (!RST) begin
            BUSY = (r_state != ST_IDLE);
            case (r_state)
                ST_MEMORY: begin
                    // The memory request is held through a stall so that
                    // the transaction stays open.
                    MEM_REQ = 1'b1;
                    MEM_WE  = (w_class == CLS_STR);
                end
                ST_WRITEBACK: begin
                    if (!STALL) begin
                        RETIRE = 1'b1;
                        PC_EN  = 1'b1;
                        REG_WE = (w_class == CLS_DP) || (w_class == CLS_LDR) ||
                                 (w_class == CLS_BL);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign PHASE         = r_state;
    assign RETIRED_COUNT = r_retired_count;

endmodule
`default_nettype wire
